bounce_gen: RTL and testbench
=============================

Name: bounce_gen

Overview:
- Synthesizable push-button bounce emulator; the inverse of the debouncer.
- Converts a clean requested level into a realistically bouncing `pb_out`: a burst of pseudo-random-width glitches, then a stable settle interval.
- Drives debouncer inputs in hardware-in-the-loop tests on the board, and serves as a stimulus source in simulation.

Parameters:
- NB_W, 4, width of the `n_bounces` input; up to 2^NB_W-1 bounces per edge.
- GLITCH_W, 4, glitch segment width is `lfsr[GLITCH_W-1:0]+1`, giving 1..2^GLITCH_W cycles.
- SETTLE_CYCLES, 16, cycles `pb_out` is held stable after the last toggle; must be >=1.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, active-low asynchronous
- level_in  in  1  clean requested button level
- n_bounces  in  NB_W  bounce count; sampled on sequence start
- pb_out  out  1  bouncing button output
- busy  out  1  high while a sequence (GLITCH or SETTLE) is active
- done  out  1  one-cycle pulse at sequence end
- toggle_cnt  out  8  `pb_out` toggles in the current/last sequence; saturates at 255

Behaviour:
- Reset (`rst`=0, async, immediate):
  - `pb_out`=0, `busy`=0, `done`=0, `toggle_cnt`=0.
  - state=IDLE, lfsr=LFSR_SEED, seg_cnt=0, bounces_left=0, target=0.
  - Reset mid-sequence aborts it; `pb_out` drops to 0 the same instant.
- LFSR:
  - 16-bit Galois, mask 16'hB400, advances every cycle out of reset.
  - A segment width is taken from the LFSR value at the edge the segment is loaded.
- FSM states: IDLE, GLITCH, SETTLE.
- IDLE:
  - At a rising edge where `level_in != pb_out`: target<=`level_in`, `pb_out`<=`level_in` (first toggle, 1-cycle latency), bounces_left<=`n_bounces`, `toggle_cnt`<=1, `busy`<=1.
  - If `n_bounces`==0: next state SETTLE, seg_cnt<=SETTLE_CYCLES-1.
  - Else: next state GLITCH, seg_cnt<=width-1.
  - If `level_in == pb_out`: stay in IDLE, outputs unchanged.
- GLITCH:
  - seg_cnt decrements each cycle.
  - When seg_cnt==0, `pb_out` toggles, `toggle_cnt` increments, and seg_cnt reloads with a new width-1.
  - Each bounce is two toggles: away from target, then back.
  - After the toggle that returns `pb_out` to target with bounces_left==1: go to SETTLE, seg_cnt<=SETTLE_CYCLES-1.
  - Otherwise bounces_left decrements on each return-to-target toggle.
  - Toggles per sequence = 1+2*`n_bounces`; `pb_out` always ends equal to target.
- SETTLE:
  - `pb_out` constant. seg_cnt counts down.
  - At 0: `done`=1 for one cycle, `busy`<=0, state IDLE.
- Simultaneous events and boundaries:
  - `level_in` changes while `busy`: ignored. In IDLE on the next cycle after `done`, a mismatch starts a new sequence (checked the cycle after `done`).
  - `level_in` glitch fully inside `busy`: no effect.
  - `n_bounces` changes mid-sequence: no effect; latched at start.
  - Width arithmetic is GLITCH_W+1 bits; no overflow at all-ones.
  - `toggle_cnt` holds its value in IDLE until the next start.
  - `done` and a new start never occur in the same cycle.

Optional Feature:
- Macro: BOUNCE_GEN_SYNC_EN.
- Defined: `level_in` passes through a 2-flop synchronizer (reset to 0) before the FSM. Start latency becomes 3 cycles; `level_in` may be asynchronous (e.g. a physical switch or another clock domain).
- Undefined: `level_in` is used directly; it must be synchronous to `clk`; latency 1 cycle.

Decomposition:
- Package bounce_pkg:
  - FSM state enum (IDLE/GLITCH/SETTLE).
  - LFSR_MASK=16'hB400.
  - Default LFSR_SEED.
  - `toggle_cnt` width constant (8).
- Sub-module lfsr16:
  - Inputs: `clk`, `rst`, seed parameter. Output: 16-bit state.
  - Free-running Galois LFSR, reused by future stimulus blocks.

Test Plan:
- `n_bounces`=0, `level_in` 0->1:
  - `pb_out` rises 1 cycle later.
  - `busy` high exactly 16 cycles, then `done` pulse.
  - `toggle_cnt`=1; `pb_out` stays 1.
- `n_bounces`=3, `level_in` 0->1:
  - Exactly 7 `pb_out` toggles; each segment 1..16 cycles and matching the LFSR reference model from seed 16'hACE1.
  - Final `pb_out`=1, then 16 stable cycles, `done`, `toggle_cnt`=7.
- `level_in` 1->0 pulsed for 3 cycles during GLITCH of a 0->1 sequence:
  - Ignored; sequence completes at 1; no new start since `level_in`=1 at IDLE.
- `level_in` 0->1 then 1->0 mid-sequence, held at 0:
  - First sequence ends at 1 with `done`.
  - The cycle after, a second sequence starts, ending at 0.
- `rst` asserted during the 2nd bounce of `n_bounces`=5:
  - `pb_out`/`busy`/`done`/`toggle_cnt` go 0 asynchronously.
  - After release the LFSR restarts from seed; an identical stimulus replay gives identical widths.
- `n_bounces`=15, both macro settings:
  - 31 toggles.
  - With BOUNCE_GEN_SYNC_EN, the first `pb_out` edge appears 3 cycles after the `level_in` change; without it, 1 cycle.

Source files
------------

// File: rtl/bounce_pkg.sv
// Shared types and constants for the push-button bounce emulator and its LFSR.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package bounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GLITCH = 2'd1,
        SETTLE = 2'd2
    } bounce_state_t;

    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    localparam int          TOGGLE_CNT_W      = 8;

    // One step of the right-shifting Galois LFSR: feedback taps applied when bit 0 falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR, restarted from SEED by reset.
// Latency: state advances one step every clock out of reset.
// Backpressure: none; it never stalls.
module lfsr16
    import bounce_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/bounce_gen.sv
// Push-button bounce emulator: a clean level change becomes a burst of random-width glitches, then a settle.
// Latency: first pb_out edge 1 cycle after level_in, 3 cycles when BOUNCE_GEN_SYNC_EN adds a 2-flop synchronizer.
// Backpressure: none; level_in is ignored while busy and a leftover mismatch starts a new burst once idle.
module bounce_gen
    import bounce_pkg::*;
#(
    parameter int          NB_W          = 4,
    parameter int          GLITCH_W      = 4,
    parameter int          SETTLE_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    level_in,
    input  logic [NB_W-1:0]         n_bounces,
    output logic                    pb_out,
    output logic                    busy,
    output logic                    done,
    output logic [TOGGLE_CNT_W-1:0] toggle_cnt
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SEG_W    = (GLITCH_W > SETTLE_W) ? GLITCH_W : SETTLE_W;

    localparam logic [SEG_W-1:0]        SETTLE_LOAD = SEG_W'(SETTLE_CYCLES - 1);
    localparam logic [SEG_W-1:0]        SEG_ONE     = SEG_W'(1);
    localparam logic [GLITCH_W:0]       WIDTH_ONE   = {{GLITCH_W{1'b0}}, 1'b1};
    localparam logic [NB_W-1:0]         NB_ONE      = NB_W'(1);
    localparam logic [TOGGLE_CNT_W-1:0] TCNT_ONE    = TOGGLE_CNT_W'(1);

    bounce_state_t state_q, state_d;

    logic [15:0]             lfsr_q;
    logic                    lfsr_unused;
    logic                    level_s;
    logic                    pb_q, pb_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    target_q, target_d;
    logic [TOGGLE_CNT_W-1:0] tcnt_q, tcnt_d, tcnt_inc;
    logic [SEG_W-1:0]        seg_q, seg_d, seg_reload;
    logic [NB_W-1:0]         left_q, left_d;
    logic [GLITCH_W:0]       glitch_width;
    logic                    start, seg_zero, returning, last_return;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_q)
    );

    // Only the low GLITCH_W bits pick a segment width; the rest just feed the sequence.
    assign lfsr_unused = ^lfsr_q[15:GLITCH_W];

`ifdef BOUNCE_GEN_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], level_in};
        end
    end

    assign level_s = sync_q[1];
`else
    assign level_s = level_in;
`endif

    // Width is computed one bit wider so an all-ones LFSR slice yields 2^GLITCH_W, not 0.
    assign glitch_width = {1'b0, lfsr_q[GLITCH_W-1:0]} + WIDTH_ONE;
    assign seg_reload   = SEG_W'(glitch_width - WIDTH_ONE);

    assign tcnt_inc    = (tcnt_q == '1) ? tcnt_q : tcnt_q + TCNT_ONE;
    assign start       = (state_q == IDLE) && (level_s != pb_q);
    assign seg_zero    = (seg_q == '0);
    assign returning   = (pb_q != target_q);
    assign last_return = seg_zero && returning && (left_q == NB_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (n_bounces == '0) ? SETTLE : GLITCH;
                end
            end
            GLITCH: begin
                if (last_return) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (seg_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pb_d     = pb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        target_d = target_q;
        tcnt_d   = tcnt_q;
        seg_d    = seg_q;
        left_d   = left_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = level_s;
                    pb_d     = level_s;
                    left_d   = n_bounces;
                    tcnt_d   = TCNT_ONE;
                    busy_d   = 1'b1;
                    seg_d    = (n_bounces == '0) ? SETTLE_LOAD : seg_reload;
                end
            end
            GLITCH: begin
                if (seg_zero) begin
                    pb_d   = ~pb_q;
                    tcnt_d = tcnt_inc;
                    // A bounce completes on the toggle that lands back on target.
                    if (returning && (left_q == NB_ONE)) begin
                        seg_d = SETTLE_LOAD;
                    end else if (returning) begin
                        left_d = left_q - NB_ONE;
                        seg_d  = seg_reload;
                    end else begin
                        seg_d = seg_reload;
                    end
                end else begin
                    seg_d = seg_q - SEG_ONE;
                end
            end
            SETTLE: begin
                if (seg_zero) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    seg_d = seg_q - SEG_ONE;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            target_q <= 1'b0;
            tcnt_q   <= '0;
            seg_q    <= '0;
            left_q   <= '0;
        end else begin
            pb_q     <= pb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            target_q <= target_d;
            tcnt_q   <= tcnt_d;
            seg_q    <= seg_d;
            left_q   <= left_d;
        end
    end

    assign pb_out     = pb_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign toggle_cnt = tcnt_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: randomized bounce counts checked against a toggle-timeline model built from the LFSR sequence.
module tb_bounce_gen;

    localparam int SETTLE = 16;
`ifdef BOUNCE_GEN_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       level_in  = 1'b0;
    logic [3:0] n_bounces = 4'd0;
    logic       pb_out, busy, done;
    logic [7:0] toggle_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int lfsr_at [0:65535];

    int   obs_t [0:63];
    int   obs_n, obs_busy, obs_done_at, obs_done_cnt;
    logic [7:0] obs_tcnt;
    bit   obs_timeout;

    int exp_t [0:63];
    int exp_n, exp_done_at, exp_busy;

    int idle_noise;

    bounce_gen #(
        .NB_W          (4),
        .GLITCH_W      (4),
        .SETTLE_CYCLES (SETTLE),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .level_in   (level_in),
        .n_bounces  (n_bounces),
        .pb_out     (pb_out),
        .busy       (busy),
        .done       (done),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    // Index of the next rising edge since reset release; edge 0 sees the seed.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic build_lfsr_table();
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < 65536; i++) begin
            lfsr_at[i] = int'(v);
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        end
    endtask

    // Expected toggle edges: each segment lasts (low nibble of the LFSR at its first edge) + 1 cycles.
    task automatic predict(input int s, input int n);
        exp_n    = 2 * n + 1;
        exp_t[0] = s;
        for (int i = 1; i < exp_n; i++) begin
            exp_t[i] = exp_t[i-1] + (lfsr_at[exp_t[i-1] % 65536] % 16) + 1;
        end
        exp_done_at = exp_t[exp_n-1] + SETTLE + 1;
        exp_busy    = exp_done_at - 1 - s;
    endtask

    // Records pb_out toggle edges, busy cycles and done until done or a cycle budget expires.
    task automatic observe(input int s, input logic tgt, input int poke_start, input int poke_len);
        logic prev;
        int   limit;
        prev         = pb_out;
        obs_n        = 0;
        obs_busy     = 0;
        obs_done_cnt = 0;
        obs_done_at  = -1;
        obs_tcnt     = 8'd0;
        obs_timeout  = 1'b0;
        limit        = s + 1200;
        while (obs_done_cnt == 0 && cyc < limit) begin
            @(negedge clk);
            if (poke_start >= 0 && cyc == s + poke_start) level_in = ~tgt;
            if (poke_start >= 0 && poke_len > 0 && cyc == s + poke_start + poke_len) level_in = tgt;
            if (cyc > s) n_bounces = 4'($urandom);
            if (pb_out !== prev) begin
                if (obs_n < 64) obs_t[obs_n] = cyc - 1;
                obs_n++;
                prev = pb_out;
            end
            if (busy === 1'b1) obs_busy++;
            if (done === 1'b1) begin
                obs_done_cnt++;
                obs_done_at = cyc;
                obs_tcnt    = toggle_cnt;
            end
        end
        if (obs_done_cnt == 0) obs_timeout = 1'b1;
    endtask

    task automatic watch_idle(input int k);
        logic       p;
        logic [7:0] t;
        idle_noise = 0;
        p = pb_out;
        t = toggle_cnt;
        repeat (k) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || pb_out !== p || toggle_cnt !== t) idle_noise++;
        end
    endtask

    task automatic go_level(input logic lvl, input int n);
        int s;
        @(negedge clk);
        n_bounces = 4'(n);
        level_in  = lvl;
        s = cyc + SYNC_DLY;
        observe(s, lvl, -1, 0);
        watch_idle(4);
    endtask

    task automatic test_reset();
        #17;
        n_checks++;
        if (pb_out !== 1'b0) begin n_fail++; $display("FAIL reset pb_out: got %b, required 0", pb_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, required 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b, required 0", done); end
        n_checks++;
        if (toggle_cnt !== 8'd0) begin n_fail++; $display("FAIL reset toggle_cnt: got %0d, required 0", toggle_cnt); end
        @(negedge clk);
        rst = 1'b1;
        watch_idle(4);
        n_checks++;
        if (idle_noise !== 0) begin n_fail++; $display("FAIL reset idle: got %0d disturbed cycles, required 0", idle_noise); end
    endtask

    task automatic test_no_bounce();
        int c, lat;
        @(negedge clk);
        n_bounces = 4'd0;
        level_in  = 1'b1;
        c = cyc;
        predict(c + SYNC_DLY, 0);
        observe(c + SYNC_DLY, 1'b1, -1, 0);
        lat = (obs_n > 0) ? obs_t[0] + 1 - c : -1;
        n_checks++;
        if (lat !== 1 + SYNC_DLY) begin n_fail++; $display("FAIL no_bounce latency: got %0d, required %0d", lat, 1 + SYNC_DLY); end
        n_checks++;
        if (obs_busy !== SETTLE) begin n_fail++; $display("FAIL no_bounce busy cycles: got %0d, required %0d", obs_busy, SETTLE); end
        n_checks++;
        if (obs_timeout || obs_done_at !== exp_done_at) begin
            n_fail++; $display("FAIL no_bounce done: got cycle %0d (timeout %0d), required %0d", obs_done_at, obs_timeout, exp_done_at);
        end
        n_checks++;
        if (obs_tcnt !== 8'd1 || obs_n !== 1) begin n_fail++; $display("FAIL no_bounce toggles: got cnt %0d seen %0d, required 1", obs_tcnt, obs_n); end
        watch_idle(8);
        n_checks++;
        if (idle_noise !== 0 || pb_out !== 1'b1) begin n_fail++; $display("FAIL no_bounce hold: got noise %0d pb %b, required 0 and 1", idle_noise, pb_out); end
    endtask

    task automatic test_three_bounces();
        int s, bad, wbad;
        go_level(1'b0, int'($urandom_range(1, 6)));
        n_checks++;
        if (pb_out !== 1'b0) begin n_fail++; $display("FAIL three_bounces setup pb_out: got %b, required 0", pb_out); end
        @(negedge clk);
        n_bounces = 4'd3;
        level_in  = 1'b1;
        s = cyc + SYNC_DLY;
        predict(s, 3);
        observe(s, 1'b1, -1, 0);
        bad  = 0;
        wbad = 0;
        for (int i = 0; i < exp_n; i++) if (i >= obs_n || obs_t[i] != exp_t[i]) bad++;
        for (int i = 1; i < obs_n && i < 64; i++) if (obs_t[i] - obs_t[i-1] < 1 || obs_t[i] - obs_t[i-1] > 16) wbad++;
        n_checks++;
        if (bad != 0 || obs_n != 7) begin n_fail++; $display("FAIL three_bounces timeline: got %0d toggles (%0d off-model), required 7 on-model", obs_n, bad); end
        n_checks++;
        if (wbad !== 0) begin n_fail++; $display("FAIL three_bounces widths: got %0d out of 1..16, required 0", wbad); end
        n_checks++;
        if (obs_timeout || obs_done_at !== exp_done_at) begin
            n_fail++; $display("FAIL three_bounces done: got cycle %0d, required %0d", obs_done_at, exp_done_at);
        end
        n_checks++;
        if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL three_bounces busy cycles: got %0d, required %0d", obs_busy, exp_busy); end
        n_checks++;
        if (obs_tcnt !== 8'd7) begin n_fail++; $display("FAIL three_bounces toggle_cnt: got %0d, required 7", obs_tcnt); end
        watch_idle(6);
        n_checks++;
        if (idle_noise !== 0 || pb_out !== 1'b1 || toggle_cnt !== 8'd7) begin
            n_fail++; $display("FAIL three_bounces idle: got noise %0d pb %b cnt %0d, required 0 1 7", idle_noise, pb_out, toggle_cnt);
        end
    endtask

    task automatic test_ignore_glitch();
        int s, bad;
        go_level(1'b0, 2);
        @(negedge clk);
        n_bounces = 4'd4;
        level_in  = 1'b1;
        s = cyc + SYNC_DLY;
        predict(s, 4);
        observe(s, 1'b1, 2, 3);
        bad = 0;
        for (int i = 0; i < exp_n; i++) if (i >= obs_n || obs_t[i] != exp_t[i]) bad++;
        n_checks++;
        if (bad != 0 || obs_n != 9) begin n_fail++; $display("FAIL ignore_glitch timeline: got %0d toggles (%0d off-model), required 9 on-model", obs_n, bad); end
        n_checks++;
        if (obs_timeout || obs_done_at !== exp_done_at) begin
            n_fail++; $display("FAIL ignore_glitch done: got cycle %0d, required %0d", obs_done_at, exp_done_at);
        end
        watch_idle(20);
        n_checks++;
        if (idle_noise !== 0 || pb_out !== 1'b1 || toggle_cnt !== 8'd9) begin
            n_fail++; $display("FAIL ignore_glitch no restart: got noise %0d pb %b cnt %0d, required 0 1 9", idle_noise, pb_out, toggle_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int s, s2, n2, bad;
        go_level(1'b0, 1);
        @(negedge clk);
        n_bounces = 4'd2;
        level_in  = 1'b1;
        s = cyc + SYNC_DLY;
        predict(s, 2);
        observe(s, 1'b1, 3, 0);
        bad = 0;
        for (int i = 0; i < exp_n; i++) if (i >= obs_n || obs_t[i] != exp_t[i]) bad++;
        n_checks++;
        if (bad != 0 || obs_n != 5 || pb_out !== 1'b1) begin
            n_fail++; $display("FAIL back_to_back first: got %0d toggles (%0d off-model) pb %b, required 5 on-model ending 1", obs_n, bad, pb_out);
        end
        n_checks++;
        if (obs_timeout || obs_done_at !== exp_done_at) begin
            n_fail++; $display("FAIL back_to_back first done: got cycle %0d, required %0d", obs_done_at, exp_done_at);
        end
        // Still at the done negedge: the pending 0 must start on the very next edge.
        n2 = int'($urandom_range(0, 5));
        n_bounces = 4'(n2);
        s2 = cyc;
        predict(s2, n2);
        observe(s2, 1'b0, -1, 0);
        bad = 0;
        for (int i = 0; i < exp_n; i++) if (i >= obs_n || obs_t[i] != exp_t[i]) bad++;
        n_checks++;
        if (bad != 0 || obs_n != exp_n) begin
            n_fail++; $display("FAIL back_to_back second: got %0d toggles (%0d off-model), required %0d on-model", obs_n, bad, exp_n);
        end
        n_checks++;
        if (obs_timeout || pb_out !== 1'b0 || obs_tcnt !== 8'(exp_n)) begin
            n_fail++; $display("FAIL back_to_back second end: got pb %b cnt %0d, required 0 and %0d", pb_out, obs_tcnt, exp_n);
        end
        watch_idle(4);
    endtask

    task automatic test_max_bounces();
        int c, bad, lat;
        @(negedge clk);
        n_bounces = 4'd15;
        level_in  = 1'b1;
        c = cyc;
        predict(c + SYNC_DLY, 15);
        observe(c + SYNC_DLY, 1'b1, -1, 0);
        lat = (obs_n > 0) ? obs_t[0] + 1 - c : -1;
        bad = 0;
        for (int i = 0; i < exp_n; i++) if (i >= obs_n || obs_t[i] != exp_t[i]) bad++;
        n_checks++;
        if (lat !== 1 + SYNC_DLY) begin n_fail++; $display("FAIL max_bounces latency: got %0d, required %0d", lat, 1 + SYNC_DLY); end
        n_checks++;
        if (bad != 0 || obs_n != 31) begin n_fail++; $display("FAIL max_bounces timeline: got %0d toggles (%0d off-model), required 31 on-model", obs_n, bad); end
        n_checks++;
        if (obs_timeout || obs_tcnt !== 8'd31 || pb_out !== 1'b1) begin
            n_fail++; $display("FAIL max_bounces end: got cnt %0d pb %b, required 31 and 1", obs_tcnt, pb_out);
        end
        watch_idle(4);
    endtask

    task automatic test_random();
        int s, n, bad;
        logic lvl;
        for (int k = 0; k < 5; k++) begin
            lvl = ~pb_out;
            n   = int'($urandom_range(0, 15));
            @(negedge clk);
            n_bounces = 4'(n);
            level_in  = lvl;
            s = cyc + SYNC_DLY;
            predict(s, n);
            observe(s, lvl, -1, 0);
            bad = 0;
            for (int i = 0; i < exp_n; i++) if (i >= obs_n || obs_t[i] != exp_t[i]) bad++;
            n_checks++;
            if (bad != 0 || obs_n != exp_n || obs_done_at != exp_done_at || obs_tcnt !== 8'(exp_n) || pb_out !== lvl) begin
                n_fail++;
                $display("FAIL random[%0d] n=%0d: got %0d toggles (%0d off-model) done %0d cnt %0d pb %b, required %0d done %0d pb %b",
                         k, n, obs_n, bad, obs_done_at, obs_tcnt, pb_out, exp_n, exp_done_at, lvl);
            end
            watch_idle(4);
        end
    endtask

    task automatic test_reset_replay();
        int   s, k, bad, limit;
        int   saved [0:2];
        logic prev;
        @(negedge clk);
        rst = 1'b0;
        level_in  = 1'b0;
        n_bounces = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        n_bounces = 4'd5;
        level_in  = 1'b1;
        s = cyc + SYNC_DLY;
        prev  = pb_out;
        k     = 0;
        limit = s + 300;
        while (k < 3 && cyc < limit) begin
            @(negedge clk);
            if (pb_out !== prev) begin
                saved[k] = cyc - 1;
                k++;
                prev = pb_out;
            end
        end
        n_checks++;
        if (k !== 3 || pb_out !== 1'b1) begin n_fail++; $display("FAIL reset_replay pre-abort: got %0d toggles pb %b, required 3 and 1", k, pb_out); end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (pb_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || toggle_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_replay abort: got pb %b busy %b done %b cnt %0d, required all 0", pb_out, busy, done, toggle_cnt);
        end
        level_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        n_bounces = 4'd5;
        level_in  = 1'b1;
        s = cyc + SYNC_DLY;
        predict(s, 5);
        observe(s, 1'b1, -1, 0);
        bad = 0;
        for (int i = 0; i < exp_n; i++) if (i >= obs_n || obs_t[i] != exp_t[i]) bad++;
        n_checks++;
        if (bad != 0 || obs_n != 11) begin n_fail++; $display("FAIL reset_replay timeline: got %0d toggles (%0d off-model), required 11 on-model", obs_n, bad); end
        bad = 0;
        for (int i = 0; i < 3; i++) if (i >= obs_n || obs_t[i] != saved[i]) bad++;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL reset_replay repeat: got %0d edges differing from aborted run, required 0", bad); end
        n_checks++;
        if (obs_timeout || obs_tcnt !== 8'd11 || pb_out !== 1'b1) begin
            n_fail++; $display("FAIL reset_replay end: got cnt %0d pb %b, required 11 and 1", obs_tcnt, pb_out);
        end
    endtask

    initial begin
        build_lfsr_table();
        test_reset();
        test_no_bounce();
        test_three_bounces();
        test_ignore_glitch();
        test_back_to_back();
        test_max_bounces();
        test_random();
        test_reset_replay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
